// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared core encodings for write-back result selection and load types
// Purpose: core-wide constants and the MEM/WB pipeline record.
//   RES_*    result-select encodings (RES_ALU, RES_MEM, RES_PC4)
//   LD_*     load-type encodings (LD_W, LD_H, LD_HU, LD_B, LD_BU)
//   REG_ZERO hard-wired zero register index
//   wb_reg_t contents of the MEM/WB pipeline register
package writeback_stage_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_sel;
        logic [2:0]  load_type;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [4:0]  write_reg;
    } wb_reg_t;

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - little-endian byte/halfword extraction with sign/zero extension
// Purpose: combinational load data alignment, shared by any load return path.
// Ports:
//   i_load_type  load-type encoding (LD_*); unknown codes behave as LD_W
//   i_off        byte offset within the word (effective address [1:0])
//   i_word       raw aligned word from memory
//   o_data       extended load value
import writeback_stage_pkg::*;

module load_extender (
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    always_comb begin
        case (i_load_type)
            LD_H:    o_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_data = {16'h0000, w_half};
            LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_data = {24'h000000, w_byte};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register and register-file write-back driver
// Purpose: registers the MEM stage, extends load data, selects the write-back value,
// drives the register file write port (committed on the falling edge) and a forwarding tap.
// Optional: WB_RETIRE_COUNT_EN adds a retired-instruction counter output.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   stall, flush         hold WB / load a bubble (flush wins)
//   mem_*                MEM stage instruction fields
//   we3, a3, wd3         register file write port
//   fwd_valid/reg/data   forwarding tap, identical to we3/a3/wd3
//   misalign             WB holds a misaligned load (write suppressed)
//   retire_count         instructions leaving WB (WB_RETIRE_COUNT_EN only)
import writeback_stage_pkg::*;

module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [1:0]        mem_result_sel,
    input  logic [2:0]        mem_load_type,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic [REG_AW-1:0] mem_write_reg,
    output logic              we3,
    output logic [REG_AW-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              misalign
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0]       retire_count
`endif
);

    wb_reg_t     r_wb;
    logic [31:0] w_load_data;
    logic [1:0]  w_off;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_we;
    logic [31:0] w_wd;

    // A flush bubble is simply an all-zero record, same as reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wb <= '0;
        end else if (!stall) begin
            r_wb.valid      <= mem_valid;
            r_wb.reg_write  <= mem_reg_write;
            r_wb.result_sel <= mem_result_sel;
            r_wb.load_type  <= mem_load_type;
            r_wb.alu_result <= mem_alu_result;
            r_wb.read_data  <= mem_read_data;
            r_wb.pc_plus4   <= mem_pc_plus4;
            r_wb.write_reg  <= mem_write_reg;
        end
    end

    assign w_off = r_wb.alu_result[1:0];

    load_extender u_load_extender (
        .i_load_type (r_wb.load_type),
        .i_off       (w_off),
        .i_word      (r_wb.read_data),
        .o_data      (w_load_data)
    );

    // Unknown load types extract as a word, so they also check word alignment.
    always_comb begin
        w_is_half = (r_wb.load_type == LD_H) || (r_wb.load_type == LD_HU);
        w_is_word = !(w_is_half || (r_wb.load_type == LD_B) || (r_wb.load_type == LD_BU));
        w_misalign = r_wb.valid && (r_wb.result_sel == RES_MEM) &&
                     ((w_is_word && (w_off != 2'd0)) || (w_is_half && w_off[0]));
    end

    always_comb begin
        case (r_wb.result_sel)
            RES_MEM: w_wd = w_load_data;
            RES_PC4: w_wd = r_wb.pc_plus4;
            default: w_wd = r_wb.alu_result;
        endcase
    end

    // r0 writes are dropped here so the forwarding tap never advertises r0.
    assign w_we = r_wb.valid && r_wb.reg_write && (r_wb.write_reg != REG_ZERO) && !w_misalign;

    assign we3       = w_we;
    assign a3        = r_wb.write_reg;
    assign wd3       = w_wd;
    assign fwd_valid = w_we;
    assign fwd_reg   = r_wb.write_reg;
    assign fwd_data  = w_wd;
    assign misalign  = w_misalign;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] r_retire_count;

    // An instruction leaves WB when it is not held, or when a flush replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_count <= 32'd0;
        end else if (r_wb.valid && (!stall || flush)) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back logic for the 5-stage pipelined core.
- It is the writer side of the register file's write port: it drives WE3/A3/WD3, which the register file commits on the falling edge.
- Performs load byte/halfword extraction and sign/zero extension.
- Selects the write-back result.
- Exports a forwarding tap to the EX-stage forwarding unit.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
REG_AW, 5, register address width

Ports:
clk  in  1  core clock, rising-edge pipeline register
rst  in  1  synchronous active-high reset
stall  in  1  hold WB contents this cycle
flush  in  1  load a bubble into WB this cycle
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes a register
mem_result_sel  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved
mem_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
mem_alu_result  in  DATA_W  ALU result / load effective address
mem_read_data  in  DATA_W  raw aligned word from data memory
mem_pc_plus4  in  DATA_W  link value
mem_write_reg  in  REG_AW  destination register
we3  out  1  register file write enable
a3  out  REG_AW  register file write address
wd3  out  DATA_W  register file write data
fwd_valid  out  1  WB holds a pending register write (equals we3)
fwd_reg  out  REG_AW  equals a3
fwd_data  out  DATA_W  equals wd3
misalign  out  1  WB holds a misaligned load

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, rst.
- Pipeline register update priority at each rising clk edge: rst > flush > stall > load.
  - rst: clear every stored field to 0, so wb_valid=0.
  - flush: wb_valid<=0; other fields don't-care, cleared to 0.
  - stall: hold all fields.
  - otherwise: capture all mem_* inputs.
- Latency: one cycle from MEM capture to we3. Write commits at the following falling edge.
- Same-cycle decode reads see the new value; no extra WB-to-ID bypass is needed.
- Load extraction (result_sel=01) is combinational from the registered fields. Little-endian; off = alu_result[1:0].
  - LW: whole word.
  - LH/LHU: halfword at bit 16*off[1], sign/zero-extended.
  - LB/LBU: byte at bit 8*off, sign/zero-extended.
  - Undefined load_type decodes as LW.
- misalign = wb_valid & result_sel==01 & ((LW & off!=0) | (LH/LHU & off[0])).
- wd3 source by result_sel:
  - 00: alu_result.
  - 01: extended load value.
  - 10: pc_plus4.
  - 11: alu_result.
- we3 = wb_valid & reg_write & (a3!=0) & !misalign.
  - Writes to r0 are suppressed here, in addition to the register file's own r0 clamp.
- a3 and wd3 are driven even when we3=0.
- Reset values: we3=0, a3=0, wd3=0, fwd_*=0, misalign=0.
- Stall with a valid writer: we3 stays high and the register file rewrites the identical value on each falling edge (idempotent). This is permitted.
- flush and stall asserted together: flush wins.
- rst asserted mid-stall: WB clears on that edge.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count [31:0]. It is a register, reset to 0.
  - Increments by 1 on each rising edge where wb_valid=1 and (stall=0 or flush=1), i.e. the instruction leaves WB.
  - Misaligned loads count too.
  - Wraps 0xFFFFFFFF to 0.
  - rst has priority over increment.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package (core-wide) holds:
  - RES_ALU/RES_MEM/RES_PC4 result-select encodings.
  - LD_W/LD_H/LD_HU/LD_B/LD_BU load-type encodings.
  - REG_ZERO constant.
- One sub-module, load_extender: combinational; inputs (load_type, off, raw word); output extended word. It is reused by any future cache-side load path.

Test Plan:
- rst=1 for 2 cycles with mem_valid=1 -> we3=0, wd3=0, a3=0, misalign=0; after release, the first captured instruction appears at the next edge.
- ALU op, dest r8, alu_result=0x0000_1234, sel=00 -> one cycle later we3=1, a3=8, wd3=0x0000_1234. Reading r8 in the same cycle after the falling edge returns 0x1234.
- Loads with read_data=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=1 -> 0x0000_007F.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
- LW off=2, dest r5 -> misalign=1, we3=0. LH off=1 -> misalign=1.
- Dest r0 with reg_write=1 -> we3=0.
- Valid write to r3 held under stall for 3 cycles, then flush+stall together -> we3 high for 3 cycles, then wb_valid=0. With WB_RETIRE_COUNT_EN, retire_count increments exactly once.
